// File: rtl/beamformer_sequencer.sv
// -----------------------------------------------------------------------------
// beamformer_sequencer
//
// Control sequencer for the brambeamformer datapath. It steps the datapath
// through one acquisition frame:
//   LOADIN -> FILTER -> FLUSH -> BEAMFORM -> SUM -> DONE -> (go) LOADIN
// It generates every address, enable, slice phase and sample index that the
// datapath consumes. It also reacts to the datapath status outputs valid_out
// (filter result valid) and usedataflag (one falling edge per consumed sum
// word).
//
// Ports
//   clk                          in   system clock, rising-edge active
//   rst                          in   asynchronous reset, active low
//   go                           in   frame start / re-arm pulse
//   valid_out                    in   filter output valid from datapath
//   usedataflag                  in   falling edge = one sum word consumed
//   bf_rst                       out  datapath reset/enable level
//   signalinen                   out  signal input enable
//   start                        out  filter run
//   signal_address    [10:0]     out  input sample address
//   readin_address    [10:0]     out  filter-result write/read address
//   filter_bram_output_write_en  out  filter BRAM write enable (= valid_out)
//   output_read_en               out  filter BRAM read enable
//   startbeamformer              out  beamformer run
//   slice_state       [1:0]      out  0 = idle delay, 1..3 = slices
//   sample_index      [15:0]     out  beamformer sample index
//   sumout_address    [9:0]      out  sum BRAM address
//   sumouten                     out  sum read-out enable
//   busy                         out  high outside LOADIN and DONE
//   done                         out  high in DONE
// -----------------------------------------------------------------------------
module beamformer_sequencer #(
   parameter int          SIG_DEPTH    = 2048,
   parameter int          FLUSH_CYCLES = 6,
   parameter int          SUM_DEPTH    = 540,
   parameter logic [15:0] SIDX_INIT    = 16'hFFFE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic        valid_out,
   input  logic        usedataflag,
   output logic        bf_rst,
   output logic        signalinen,
   output logic        start,
   output logic [10:0] signal_address,
   output logic [10:0] readin_address,
   output logic        filter_bram_output_write_en,
   output logic        output_read_en,
   output logic        startbeamformer,
   output logic [1:0]  slice_state,
   output logic [15:0] sample_index,
   output logic [9:0]  sumout_address,
   output logic        sumouten,
   output logic        busy,
   output logic        done
);

   // Flush counter width; the counter only has to reach FLUSH_CYCLES-1.
   localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [10:0]    SIG_LAST   = 11'(SIG_DEPTH - 1);
   localparam logic [9:0]     SUM_LAST   = 10'(SUM_DEPTH - 1);
   localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_LOADIN   = 3'd0,
      ST_FILTER   = 3'd1,
      ST_FLUSH    = 3'd2,
      ST_BEAMFORM = 3'd3,
      ST_SUM      = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   state_t          state_q;
   logic [FCW-1:0]  flush_cnt_q;
   logic            udf_q;
   logic            udf_fall_s;

   logic            bf_rst_q;
   logic            signalinen_q;
   logic            start_q;
   logic [10:0]     signal_address_q;
   logic [10:0]     readin_address_q;
   logic            output_read_en_q;
   logic            startbeamformer_q;
   logic [1:0]      slice_state_q;
   logic [15:0]     sample_index_q;
   logic [9:0]      sumout_address_q;
   logic            sumouten_q;
   logic            busy_q;
   logic            done_q;

   // Delayed copy of usedataflag used for falling-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         udf_q <= 1'b0;
      end else begin
         udf_q <= usedataflag;
      end
   end

   // Falling edge of usedataflag: high last cycle, low now. The FSM only
   // acts on it while in BEAMFORM.
   always_comb begin
      udf_fall_s = 1'b0;
      if (udf_q && !usedataflag) begin
         udf_fall_s = 1'b1;
      end else begin
         udf_fall_s = 1'b0;
      end
   end

   // Frame FSM together with all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q           <= ST_LOADIN;
         flush_cnt_q       <= '0;
         bf_rst_q          <= 1'b0;
         signalinen_q      <= 1'b0;
         start_q           <= 1'b0;
         signal_address_q  <= 11'd0;
         readin_address_q  <= 11'd0;
         output_read_en_q  <= 1'b0;
         startbeamformer_q <= 1'b0;
         slice_state_q     <= 2'd0;
         sample_index_q    <= SIDX_INIT;
         sumout_address_q  <= 10'd0;
         sumouten_q        <= 1'b0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
      end else begin
         case (state_q)
            ST_LOADIN: begin
               signalinen_q <= 1'b1;
               bf_rst_q     <= 1'b1;
               if (go) begin
                  state_q          <= ST_FILTER;
                  signal_address_q <= 11'd0;
                  start_q          <= 1'b1;
                  busy_q           <= 1'b1;
               end else begin
                  busy_q <= 1'b0;
               end
            end

            ST_FILTER: begin
               if (valid_out) begin
                  readin_address_q <= readin_address_q + 11'd1;
               end else begin
                  readin_address_q <= readin_address_q;
               end
               // Leave while the last address is still presented so the
               // address register never wraps back to zero.
               if (signal_address_q == SIG_LAST) begin
                  state_q     <= ST_FLUSH;
                  start_q     <= 1'b0;
                  flush_cnt_q <= '0;
               end else begin
                  signal_address_q <= signal_address_q + 11'd1;
               end
            end

            ST_FLUSH: begin
               if (flush_cnt_q == FLUSH_LAST) begin
                  // The clear wins over a write-back arriving this cycle.
                  readin_address_q  <= 11'd0;
                  slice_state_q     <= 2'd0;
                  sample_index_q    <= SIDX_INIT;
                  state_q           <= ST_BEAMFORM;
                  bf_rst_q          <= 1'b0;
                  start_q           <= 1'b0;
                  output_read_en_q  <= 1'b1;
                  startbeamformer_q <= 1'b1;
               end else begin
                  flush_cnt_q <= flush_cnt_q + FCW'(1);
                  if (valid_out) begin
                     readin_address_q <= readin_address_q + 11'd1;
                  end else begin
                     readin_address_q <= readin_address_q;
                  end
               end
            end

            ST_BEAMFORM: begin
               slice_state_q <= slice_state_q + 2'd1;
               // Entering a slice (1..3) steps the sample; leaving slice 3
               // steps the filter-result read address.
               if (slice_state_q != 2'd3) begin
                  sample_index_q <= sample_index_q + 16'd1;
               end else begin
                  readin_address_q <= readin_address_q + 11'd1;
               end
               if (udf_fall_s) begin
                  if (sumout_address_q == SUM_LAST) begin
                     sumout_address_q  <= 10'd0;
                     state_q           <= ST_SUM;
                     startbeamformer_q <= 1'b0;
                     output_read_en_q  <= 1'b0;
                     sumouten_q        <= 1'b1;
                  end else begin
                     sumout_address_q <= sumout_address_q + 10'd1;
                  end
               end else begin
                  sumout_address_q <= sumout_address_q;
               end
            end

            ST_SUM: begin
               if (sumout_address_q == SUM_LAST) begin
                  sumout_address_q <= 10'd0;
                  state_q          <= ST_DONE;
                  sumouten_q       <= 1'b0;
                  done_q           <= 1'b1;
                  busy_q           <= 1'b0;
               end else begin
                  sumout_address_q <= sumout_address_q + 10'd1;
               end
            end

            ST_DONE: begin
               if (go) begin
                  state_q          <= ST_LOADIN;
                  flush_cnt_q      <= '0;
                  signal_address_q <= 11'd0;
                  readin_address_q <= 11'd0;
                  sumout_address_q <= 10'd0;
                  slice_state_q    <= 2'd0;
                  sample_index_q   <= SIDX_INIT;
                  signalinen_q     <= 1'b1;
                  bf_rst_q         <= 1'b1;
                  done_q           <= 1'b0;
                  busy_q           <= 1'b0;
               end else begin
                  done_q <= 1'b1;
               end
            end

            default: begin
               // Unreachable encoding: fall back to a clean LOADIN.
               state_q           <= ST_LOADIN;
               flush_cnt_q       <= '0;
               bf_rst_q          <= 1'b0;
               signalinen_q      <= 1'b0;
               start_q           <= 1'b0;
               signal_address_q  <= 11'd0;
               readin_address_q  <= 11'd0;
               output_read_en_q  <= 1'b0;
               startbeamformer_q <= 1'b0;
               slice_state_q     <= 2'd0;
               sample_index_q    <= SIDX_INIT;
               sumout_address_q  <= 10'd0;
               sumouten_q        <= 1'b0;
               busy_q            <= 1'b0;
               done_q            <= 1'b0;
            end
         endcase
      end
   end

   // Write-back enable follows the datapath with zero latency.
   assign filter_bram_output_write_en = valid_out;

   assign bf_rst          = bf_rst_q;
   assign signalinen      = signalinen_q;
   assign start           = start_q;
   assign signal_address  = signal_address_q;
   assign readin_address  = readin_address_q;
   assign output_read_en  = output_read_en_q;
   assign startbeamformer = startbeamformer_q;
   assign slice_state     = slice_state_q;
   assign sample_index    = sample_index_q;
   assign sumout_address  = sumout_address_q;
   assign sumouten        = sumouten_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule

// File: doc/beamformer_sequencer.md
Name: beamformer_sequencer

Overview:
- Synthesizable control sequencer that drives the brambeamformer datapath through one complete acquisition frame: load-in, filtering, filter flush, beamforming and sum read-out.
- Acts as the initiator side of the brambeamformer control interface. It generates every address, enable, slice phase and sample index the datapath consumes, and it reacts to the datapath's valid_out and usedataflag status outputs.

Parameters:
- SIG_DEPTH, 2048, number of input signal samples streamed through the filter.
- FLUSH_CYCLES, 6, cycles spent draining the filter pipeline after the last sample.
- SUM_DEPTH, 540, number of summed output words.
- SIDX_INIT, 16'hFFFE, sample_index load value (-2), which absorbs the BRAM read latency.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- go  in  1  frame start/re-arm pulse, sampled on clk.
- valid_out  in  1  filter output valid from the datapath.
- usedataflag  in  1  datapath flag; each 1->0 transition marks one consumed sum word.
- bf_rst  out  1  datapath reset/enable level.
- signalinen  out  1  signal input enable.
- start  out  1  filter run.
- signal_address  out  11  input sample address.
- readin_address  out  11  filter-result write/read address.
- filter_bram_output_write_en  out  1  filter result BRAM write enable.
- output_read_en  out  1  filter BRAM read enable.
- startbeamformer  out  1  beamformer run.
- slice_state  out  2  slice phase: 0 = idle_delay, 1..3 = slices.
- sample_index  out  16  beamformer sample index.
- sumout_address  out  10  sum BRAM address.
- sumouten  out  1  sum read-out enable.
- busy  out  1  high in every state except LOADIN and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst=0, asynchronous) sets state=LOADIN and all addresses, counters, slice_state and enables to 0. sample_index=SIDX_INIT. Reset asserted mid-frame aborts immediately; there is no resume.
- filter_bram_output_write_en = valid_out, combinational, in every state.
- All other outputs are registered.
- States: LOADIN, FILTER, FLUSH, BEAMFORM, SUM, DONE.
- LOADIN:
  - signalinen=1, bf_rst=1.
  - go=1 -> FILTER on the next edge; signal_address=0.
- FILTER:
  - start=1.
  - signal_address +1 per cycle.
  - The cycle that presents SIG_DEPTH-1 transitions to FLUSH, so the address is never wrapped.
- readin_address in FILTER and FLUSH: +1 on each cycle valid_out=1. It wraps modulo 2^11.
- FLUSH:
  - Counter runs 0..FLUSH_CYCLES-1.
  - On the last count: readin_address=0, slice_state=0, sample_index=SIDX_INIT, -> BEAMFORM.
  - A valid_out on that same cycle is overridden by the clear.
- BEAMFORM:
  - bf_rst=0, start=0, output_read_en=1, startbeamformer=1.
  - slice_state cycles 0->1->2->3->0, one step per clk.
  - Entering slices 1, 2 and 3: sample_index +1 (wraps modulo 2^16).
  - Leaving slice 3: readin_address +1.
  - usedataflag is registered once internally. A detected 1->0 edge increments sumout_address.
  - Edge detected while sumout_address=SUM_DEPTH-1: sumout_address=0, -> SUM.
  - usedataflag edges outside BEAMFORM are ignored.
- SUM:
  - startbeamformer=0, output_read_en=0, sumouten=1.
  - sumout_address +1 per cycle.
  - At SUM_DEPTH-1: sumout_address=0, -> DONE.
  - SUM_DEPTH words are presented: addresses 0..539, one cycle each.
- DONE:
  - sumouten=0, done=1, holds.
  - go=1 -> LOADIN; all addresses cleared, sample_index=SIDX_INIT.
- go is ignored in FILTER, FLUSH, BEAMFORM and SUM.

Test Plan:
- Reset and idle: hold rst=0, release, no go -> all addresses 0, sample_index=16'hFFFE, signalinen=1, bf_rst=1, busy=0.
- Filter sweep: go pulse -> start high for exactly 2048 cycles with signal_address 0..2047, then 6 FLUSH cycles, then startbeamformer=1 with readin_address=0.
- valid_out write-back: valid_out high for 100 cycles in FILTER -> readin_address=100 at that point; filter_bram_output_write_en mirrors valid_out with zero latency.
- Slice phasing: in BEAMFORM over 8 cycles -> slice_state 0,1,2,3,0,1,2,3; sample_index -2 -> +4 (i.e. 4); readin_address=2.
- Sum hand-off: 540 usedataflag falling edges in BEAMFORM -> transition to SUM; sumouten high exactly 540 cycles with addresses 0..539, then done=1. A go pulse during BEAMFORM has no effect.
- Mid-frame reset: rst=0 during SUM at sumout_address=200 -> outputs take reset values asynchronously, before the next clk edge; state LOADIN after release.
